// File: rtl/clkdiv_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clkdiv_pkg
//  Description : Shared constants and types for the multi-channel tone
//                divider bank (default channel count, divisor width,
//                silent-divisor threshold, divisor type).
//  Revision    : 1.0 - initial release
// ============================================================================
package clkdiv_pkg;

    localparam int C_DEF_CH            = 4;
    localparam int C_DEF_W             = 32;
    // Divisors below this value have a zero half-period and keep the channel silent.
    localparam int C_SILENT_DIV_THRESH = 2;

    typedef logic [C_DEF_W-1:0] div_t;

endpackage
`default_nettype wire

// File: rtl/clkdiv_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : clkdiv_bank_if
//  Description : Load/enable/tone bundle between the score decoder (master)
//                and the divider bank (slave). The mix_out level is only
//                present when CLKDIV_BANK_MIX_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface clkdiv_bank_if #(
    parameter int CH = clkdiv_pkg::C_DEF_CH,
    parameter int W  = clkdiv_pkg::C_DEF_W
);
    localparam int C_CHW = (CH > 1) ? $clog2(CH) : 1;

    logic             load;
    logic [C_CHW-1:0] load_ch;
    logic [W-1:0]     load_div;
    logic [CH-1:0]    en;
    logic [CH-1:0]    tone_out;
    logic [CH-1:0]    edge_pulse;

`ifdef CLKDIV_BANK_MIX_EN
    localparam int C_MIXW = $clog2(CH + 1);
    logic [C_MIXW-1:0] mix_out;

    modport master (output load, load_ch, load_div, en,
                    input  tone_out, edge_pulse, mix_out);
    modport slave  (input  load, load_ch, load_div, en,
                    output tone_out, edge_pulse, mix_out);
`else
    modport master (output load, load_ch, load_div, en,
                    input  tone_out, edge_pulse);
    modport slave  (input  load, load_ch, load_div, en,
                    output tone_out, edge_pulse);
`endif

endinterface
`default_nettype wire

// File: rtl/clkdiv_bank_chan.sv
`default_nettype none
// ============================================================================
//  Module      : clkdiv_chan
//  Description : One tone channel: half-period counter, active/pending
//                divisor pair, square-wave output and rising-edge pulse.
//                Divisor changes only take effect at a toggle, while
//                disabled, or while silent, so the output never glitches.
//  Revision    : 1.0 - initial release
// ============================================================================
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int W = C_DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load_we,
    input  logic [W-1:0] load_div,
    output logic         tone_out,
    output logic         edge_pulse
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] act_div_q, act_div_d;
    logic [W-1:0] pend_div_q, pend_div_d;
    logic         tone_q, tone_d;
    logic         edge_q, edge_d;

    logic [W-1:0] w_half;
    logic         w_silent;
    logic         w_wrap;

    // Next-state: pending load, then disabled/silent/running counter behaviour.
    always_comb begin
        w_half     = act_div_q >> 1;
        w_silent   = (act_div_q < W'(C_SILENT_DIV_THRESH));
        w_wrap     = (cnt_q == (w_half - W'(1)));

        pend_div_d = load_we ? load_div : pend_div_q;
        cnt_d      = cnt_q;
        act_div_d  = act_div_q;
        tone_d     = tone_q;
        edge_d     = 1'b0;

        if (!en || w_silent) begin
            // Idle channels track the pending divisor so a new value is
            // used as soon as the channel starts running.
            cnt_d     = '0;
            tone_d    = 1'b0;
            act_div_d = pend_div_q;
        end else if (w_wrap) begin
            // Toggle event: the registered pending value is adopted here, so a
            // load landing in this same cycle waits for the next toggle.
            cnt_d     = '0;
            tone_d    = ~tone_q;
            edge_d    = ~tone_q;
            act_div_d = pend_div_q;
        end else begin
            cnt_d     = cnt_q + W'(1);
        end
    end

    // Channel state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            act_div_q  <= '0;
            pend_div_q <= '0;
            tone_q     <= 1'b0;
            edge_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            act_div_q  <= act_div_d;
            pend_div_q <= pend_div_d;
            tone_q     <= tone_d;
            edge_q     <= edge_d;
        end
    end

    assign tone_out   = tone_q;
    assign edge_pulse = edge_q;

endmodule
`default_nettype wire

// File: rtl/clkdiv_bank.sv
`default_nettype none
// ============================================================================
//  Module      : clkdiv_bank
//  Description : CH independent glitch-free tone dividers. Decodes the load
//                strobe to one channel (out-of-range indices ignored) and,
//                when CLKDIV_BANK_MIX_EN is defined, registers a popcount of
//                the tone outputs as a multi-level mix value.
//  Revision    : 1.0 - initial release
// ============================================================================
module clkdiv_bank
    import clkdiv_pkg::*;
#(
    parameter int CH = C_DEF_CH,
    parameter int W  = C_DEF_W
) (
    input  logic          clk,
    input  logic          rst,
    clkdiv_bank_if.slave  bus
);

    localparam int               C_CHW    = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [C_CHW:0]   C_CH_LIM = (C_CHW + 1)'(CH);

    logic          w_load_ok;
    logic [CH-1:0] w_load_we;
    logic [CH-1:0] w_tone;
    logic [CH-1:0] w_edge;

    // A strobe addressing a non-existent channel is dropped entirely.
    always_comb begin
        w_load_ok = bus.load && ({1'b0, bus.load_ch} < C_CH_LIM);
    end

    generate
        for (genvar i = 0; i < CH; i++) begin : g_chan
            assign w_load_we[i] = w_load_ok && (bus.load_ch == C_CHW'(i));

            clkdiv_chan #(
                .W (W)
            ) u_chan (
                .clk        (clk),
                .rst        (rst),
                .en         (bus.en[i]),
                .load_we    (w_load_we[i]),
                .load_div   (bus.load_div),
                .tone_out   (w_tone[i]),
                .edge_pulse (w_edge[i])
            );
        end
    endgenerate

    assign bus.tone_out   = w_tone;
    assign bus.edge_pulse = w_edge;

`ifdef CLKDIV_BANK_MIX_EN
    localparam int C_MIXW = $clog2(CH + 1);

    logic [C_MIXW-1:0] mix_q, mix_d;

    // Count of channels currently high.
    always_comb begin
        mix_d = '0;
        for (int k = 0; k < CH; k++) begin
            mix_d = mix_d + C_MIXW'(w_tone[k]);
        end
    end

    // Mix level register; lags tone_out by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mix_q <= '0;
        end else begin
            mix_q <= mix_d;
        end
    end

    assign bus.mix_out = mix_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clkdiv_bank
//  Description : Directed vectors for the tone divider bank (CH=4 main DUT,
//                CH=3 DUT for out-of-range channel index). Optional mix
//                checks compiled with CLKDIV_BANK_MIX_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clkdiv_bank;
    import clkdiv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clkdiv_bank_if #(.CH(4), .W(32)) b4 ();
    clkdiv_bank_if #(.CH(3), .W(32)) b3 ();

    clkdiv_bank #(.CH(4), .W(32)) dut  (.clk(clk), .rst(rst), .bus(b4));
    clkdiv_bank #(.CH(3), .W(32)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic       load;
        logic [1:0] load_ch;
        div_t       load_div;
        logic [3:0] en;
        logic [3:0] exp_tone;
        logic [3:0] exp_edge;
    } vec_t;

    vec_t vecs[41];

    task automatic chk(input string name, input int cyc,
                       input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, want);
    endtask

    task automatic drv4(input logic ld, input logic [1:0] ch,
                        input div_t dv, input logic [3:0] e);
        b4.load     = ld;
        b4.load_ch  = ch;
        b4.load_div = dv;
        b4.en       = e;
    endtask

    task automatic drv3(input logic ld, input logic [1:0] ch,
                        input div_t dv, input logic [2:0] e);
        b3.load     = ld;
        b3.load_ch  = ch;
        b3.load_div = dv;
        b3.en       = e;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drv4(1'b0, 2'd0, '0, 4'b0);
        drv3(1'b0, 2'd0, '0, 3'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0] et, ee;
    logic       t0, t1;
    logic [3:0] prev_tone;

    initial begin
        drv4(1'b0, 2'd0, '0, 4'b0);
        drv3(1'b0, 2'd0, '0, 3'b0);

        // ---- A: ch0 div=10, table-driven ----
        for (int k = 0; k < 41; k++) begin
            vecs[k].load     = (k == 0);
            vecs[k].load_ch  = 2'd0;
            vecs[k].load_div = (k == 0) ? 32'd10 : 32'd0;
            vecs[k].en       = (k >= 2) ? 4'b0001 : 4'b0000;
            vecs[k].exp_tone = (k >= 7 && ((k - 7) / 5) % 2 == 0) ? 4'b0001 : 4'b0000;
            vecs[k].exp_edge = (k >= 7 && (k - 7) % 10 == 0) ? 4'b0001 : 4'b0000;
        end
        do_reset();
        for (int k = 0; k < 41; k++) begin
            @(negedge clk);
            chk("A_tone", k, 32'(b4.tone_out), 32'(vecs[k].exp_tone));
            chk("A_edge", k, 32'(b4.edge_pulse), 32'(vecs[k].exp_edge));
`ifdef CLKDIV_BANK_MIX_EN
            if (k == 0) chk("A_reset_mix", k, 32'(b4.mix_out), 32'd0);
`endif
            drv4(vecs[k].load, vecs[k].load_ch, vecs[k].load_div, vecs[k].en);
        end

        // ---- B: ch1 div=7 (period 6), ch2 div=1 (silent) ----
        do_reset();
        for (int k = 0; k < 31; k++) begin
            @(negedge clk);
            t1 = (k >= 6 && ((k - 6) / 3) % 2 == 0);
            et = t1 ? 4'b0010 : 4'b0000;
            ee = (k >= 6 && (k - 6) % 6 == 0) ? 4'b0010 : 4'b0000;
            chk("B_tone", k, 32'(b4.tone_out), 32'(et));
            chk("B_edge", k, 32'(b4.edge_pulse), 32'(ee));
            drv4(k < 2, (k == 0) ? 2'd1 : 2'd2, (k == 0) ? 32'd7 : 32'd1,
                 (k >= 3) ? 4'b0110 : 4'b0000);
        end

        // ---- C: div 10 -> 20 loaded mid high half ----
        do_reset();
        for (int k = 0; k < 46; k++) begin
            @(negedge clk);
            if (k < 7)       t0 = 1'b0;
            else if (k < 12) t0 = 1'b1;
            else             t0 = (((k - 12) / 10) % 2 == 1);
            ee = (k == 7 || (k >= 12 && (k - 12) % 20 == 10)) ? 4'b0001 : 4'b0000;
            chk("C_tone", k, 32'(b4.tone_out), 32'(t0));
            chk("C_edge", k, 32'(b4.edge_pulse), 32'(ee));
            drv4(k == 0 || k == 9, 2'd0, (k == 0) ? 32'd10 : 32'd20,
                 (k >= 2) ? 4'b0001 : 4'b0000);
        end

        // ---- D: load coincident with toggle event (end of cycle 11) ----
        do_reset();
        for (int k = 0; k < 41; k++) begin
            @(negedge clk);
            if (k < 7)       t0 = 1'b0;
            else if (k < 12) t0 = 1'b1;
            else if (k < 17) t0 = 1'b0;
            else             t0 = (((k - 17) / 10) % 2 == 0);
            ee = (k == 7 || (k >= 17 && (k - 17) % 20 == 0)) ? 4'b0001 : 4'b0000;
            chk("D_tone", k, 32'(b4.tone_out), 32'(t0));
            chk("D_edge", k, 32'(b4.edge_pulse), 32'(ee));
            drv4(k == 0 || k == 11, 2'd0, (k == 0) ? 32'd10 : 32'd20,
                 (k >= 2) ? 4'b0001 : 4'b0000);
        end

        // ---- E: en dropped while high, then re-enabled ----
        do_reset();
        for (int k = 0; k < 31; k++) begin
            @(negedge clk);
            t0 = (k >= 7 && k <= 9) || (k >= 19 && ((k - 19) / 5) % 2 == 0);
            ee = (k == 7 || (k >= 19 && (k - 19) % 10 == 0)) ? 4'b0001 : 4'b0000;
            chk("E_tone", k, 32'(b4.tone_out), 32'(t0));
            chk("E_edge", k, 32'(b4.edge_pulse), 32'(ee));
            drv4(k == 0, 2'd0, 32'd10,
                 ((k >= 2 && k < 9) || k >= 14) ? 4'b0001 : 4'b0000);
        end

        // ---- F: asynchronous reset mid-run clears state and pending loads ----
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 9) chk("F_pre_tone", k, 32'(b4.tone_out), 32'h1);
            drv4(k < 2, (k == 1) ? 2'd1 : 2'd0, (k == 1) ? 32'd7 : 32'd10,
                 (k >= 3) ? 4'b0011 : 4'b0000);
        end
        #2 rst = 1'b1;
        #1;
        chk("F_async_tone", 9, 32'(b4.tone_out), 32'h0);
        chk("F_async_edge", 9, 32'(b4.edge_pulse), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("F_post_tone", k, 32'(b4.tone_out), 32'h0);
`ifdef CLKDIV_BANK_MIX_EN
            chk("F_post_mix", k, 32'(b4.mix_out), 32'h0);
`endif
        end

        // ---- G: CH=3, load_ch=3 ignored; then valid load starts enabled channel ----
        do_reset();
        for (int k = 0; k < 28; k++) begin
            @(negedge clk);
            et = (k == 24 || k == 25) ? 4'b0100 : 4'b0000;
            ee = (k == 24) ? 4'b0100 : 4'b0000;
            chk("G_tone", k, 32'(b3.tone_out), 32'(et));
            chk("G_edge", k, 32'(b3.edge_pulse), 32'(ee));
            drv3(k == 0 || k == 20, (k == 0) ? 2'd3 : 2'd2,
                 (k == 0) ? 32'd10 : 32'd4, (k >= 2) ? 3'b111 : 3'b000);
        end

`ifdef CLKDIV_BANK_MIX_EN
        // ---- H: ch0 div=4, ch1 div=8, mix follows popcount one cycle late ----
        do_reset();
        prev_tone = 4'b0;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            t0 = (k >= 5 && ((k - 5) / 2) % 2 == 0);
            t1 = (k >= 7 && ((k - 7) / 4) % 2 == 0);
            et = {2'b00, t1, t0};
            chk("H_tone", k, 32'(b4.tone_out), 32'(et));
            chk("H_mix", k, 32'(b4.mix_out),
                32'(prev_tone[0]) + 32'(prev_tone[1]));
            prev_tone = et;
            drv4(k < 2, (k == 1) ? 2'd1 : 2'd0, (k == 1) ? 32'd8 : 32'd4,
                 (k >= 3) ? 4'b0011 : 4'b0000);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
